// File: rtl/vga_wbm_arb.sv
// Wishbone B3 read-burst arbiter sharing one master port between the VGA video line fetch and the cursor-buffer fetch.
// Optional build macro VGA_ARB_STARVE_GUARD_EN adds a starvation guard for the cursor; without it video has strict priority.
//
// state | meaning
// IDLE  | no bus cycle; arbitrates between the two requesters
// VID   | video burst in progress
// CUR   | cursor burst in progress
module vga_wbm_arb #(
    parameter int AW         = 30,
    parameter int LW         = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_adr_i,
    input  logic [LW-1:0] vid_len_i,
    output logic          vid_gnt_o,
    output logic          vid_ack_o,
    output logic          vid_err_o,
    input  logic          cur_req_i,
    input  logic [AW-1:0] cur_adr_i,
    input  logic [LW-1:0] cur_len_i,
    output logic          cur_gnt_o,
    output logic          cur_ack_o,
    output logic          cur_err_o,
    output logic [31:0]   dat_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic [31:0]   wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, VID, CUR} state_t;

    state_t        state, state_nxt;
    logic          rdy;
    logic [AW-1:0] adr_q;
    logic [LW-1:0] cnt_q;
    logic          starved;
    logic          pick_vid, pick_cur;
    logic          last_beat, burst_end, busy;

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    logic [SW-1:0] starve_q;

    assign starved = (starve_q == SW'(STARVE_LIM));

    // Counts video wins while the cursor is kept waiting; any idle edge without a cursor request forgives it.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            starve_q <= '0;
        end else if (state == IDLE) begin
            if (pick_cur || !cur_req_i)
                starve_q <= '0;
            else if (pick_vid && !starved)
                starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign starved = (STARVE_LIM < 0);
`endif

    assign busy      = (state != IDLE);
    assign last_beat = (cnt_q == '0);
    assign burst_end = busy && (wbm_err_i || (wbm_ack_i && last_beat));

    always_comb begin
        pick_vid = rdy && vid_req_i && !(cur_req_i && starved);
        pick_cur = rdy && cur_req_i && !pick_vid;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_vid)
                    state_nxt = VID;
                else if (pick_cur)
                    state_nxt = CUR;
            end
            VID, CUR: begin
                if (burst_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdy holds off arbitration for the first cycle after reset release.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state <= IDLE;
            rdy   <= 1'b0;
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            rdy   <= 1'b1;
            if (state == IDLE) begin
                if (pick_vid) begin
                    adr_q <= vid_adr_i;
                    cnt_q <= vid_len_i;
                end else if (pick_cur) begin
                    adr_q <= cur_adr_i;
                    cnt_q <= cur_len_i;
                end
            end else if (wbm_ack_i && !wbm_err_i) begin
                adr_q <= adr_q + AW'(1);
                if (!last_beat)
                    cnt_q <= cnt_q - LW'(1);
            end
        end
    end

    assign wbm_cyc_o = busy;
    assign wbm_stb_o = busy;
    assign wbm_adr_o = adr_q;
    assign wbm_cti_o = busy ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wbm_bte_o = 2'b00;
    assign dat_o     = busy ? wbm_dat_i : 32'h0;

    // Error wins over a coincident ack so the requester never sees both.
    assign vid_gnt_o = (state == VID);
    assign cur_gnt_o = (state == CUR);
    assign vid_ack_o = vid_gnt_o && wbm_ack_i && !wbm_err_i;
    assign cur_ack_o = cur_gnt_o && wbm_ack_i && !wbm_err_i;
    assign vid_err_o = vid_gnt_o && wbm_err_i;
    assign cur_err_o = cur_gnt_o && wbm_err_i;

endmodule

// File: tb/tb_vga_wbm_arb.sv
// Self-checking bench for vga_wbm_arb: directed scenarios plus randomized bursts against a grant-level reference model.
module tb_vga_wbm_arb;
    localparam int AW  = 30;
    localparam int LW  = 4;
    localparam int LIM = 4;
    localparam int NO_ERR = 99;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vid_req, cur_req;
    logic [AW-1:0] vid_adr, cur_adr;
    logic [LW-1:0] vid_len, cur_len;
    logic          vid_gnt, vid_ack, vid_err, cur_gnt, cur_ack, cur_err;
    logic [31:0]   dat, wbm_dat;
    logic          wbm_cyc, wbm_stb, wbm_ack, wbm_err;
    logic [AW-1:0] wbm_adr;
    logic [2:0]    wbm_cti;
    logic [1:0]    wbm_bte;

    int checks = 0;
    int errors = 0;
    int starve_m = 0;

    always #5 clk = ~clk;

    vga_wbm_arb #(.AW(AW), .LW(LW), .STARVE_LIM(LIM)) dut (
        .wb_clk_i(clk), .arst_i(rst_n),
        .vid_req_i(vid_req), .vid_adr_i(vid_adr), .vid_len_i(vid_len),
        .vid_gnt_o(vid_gnt), .vid_ack_o(vid_ack), .vid_err_o(vid_err),
        .cur_req_i(cur_req), .cur_adr_i(cur_adr), .cur_len_i(cur_len),
        .cur_gnt_o(cur_gnt), .cur_ack_o(cur_ack), .cur_err_o(cur_err),
        .dat_o(dat),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_adr_o(wbm_adr),
        .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_dat_i(wbm_dat)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: who wins when requests (v, c) meet an idle bus, and the starvation bookkeeping.
    task automatic arbitrate(input bit v, input bit c, output bit win_cur);
        bit guard;
`ifdef VGA_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        win_cur = c && (!v || (guard && starve_m == LIM));
        if (win_cur)
            starve_m = 0;
        else if (c)
            starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
        else
            starve_m = 0;
    endtask

    task automatic idle_gap(input int n);
        vid_req = 1'b0;
        cur_req = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        starve_m = 0;
    endtask

    // Acts as the Wishbone slave for one burst, checking every cycle of it.
    task automatic run_burst(input string tag, input bit exp_cur, input logic [AW-1:0] a,
                             input int len, input int waits, input int err_beat, input bit drop);
        bit got = 1'b0;
        logic [AW-1:0] ea;
        logic [3:0] resp;
        bit is_beat, e;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            #1;
            if (wbm_cyc) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, {63'd0, got}, 64'd1);
        if (!got) return;
        chk({tag, "_bte"}, {62'd0, wbm_bte}, 64'd0);
        if (drop) begin
            vid_req = 1'b0;
            cur_req = 1'b0;
        end
        for (int b = 0; b <= len; b++) begin
            e = 1'b0;
            for (int w = 0; w <= waits; w++) begin
                is_beat = (w == waits);
                e       = is_beat && (b == err_beat);
                wbm_ack = is_beat && !e;
                wbm_err = e;
                wbm_dat = $urandom;
                #1;
                ea = a + AW'(b);
                chk({tag, "_bus"}, {27'd0, wbm_cyc, wbm_stb, vid_gnt, cur_gnt, wbm_adr, wbm_cti},
                    {27'd0, 1'b1, 1'b1, !exp_cur, exp_cur, ea, (b == len) ? 3'b111 : 3'b010});
                resp = 4'b0000;
                if (is_beat && !e) resp = exp_cur ? 4'b0010 : 4'b1000;
                if (e)             resp = exp_cur ? 4'b0001 : 4'b0100;
                chk({tag, "_resp"}, {60'd0, vid_ack, vid_err, cur_ack, cur_err}, {60'd0, resp});
                if (is_beat)
                    chk({tag, "_dat"}, {32'd0, dat}, {32'd0, wbm_dat});
                @(negedge clk);
            end
            if (e) break;
        end
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
        #1;
        chk({tag, "_end"}, {58'd0, wbm_cyc, wbm_stb, vid_gnt, cur_gnt, vid_err, cur_err}, 64'd0);
    endtask

    initial begin
        bit wc;
        bit v, c;
        logic [AW-1:0] ra;
        int rl, rw, re;
        rst_n = 1'b0;
        vid_req = 1'b0; cur_req = 1'b0;
        vid_adr = '0; cur_adr = '0; vid_len = '0; cur_len = '0;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat = 32'hDEAD_BEEF;
        #12;
        chk("reset_outs", {wbm_cyc, wbm_stb, vid_gnt, cur_gnt, wbm_adr, wbm_cti, wbm_bte, dat},
            64'd0);

        // Four-beat video burst at 0x100 with zero waits.
        @(negedge clk);
        rst_n = 1'b1;
        vid_req = 1'b1; vid_adr = AW'(32'h100); vid_len = LW'(3);
        @(negedge clk);
        #1;
        chk("first_arb_wait", {63'd0, wbm_cyc}, 64'd0);
        arbitrate(1'b1, 1'b0, wc);
        run_burst("vid4", wc, AW'(32'h100), 3, 0, NO_ERR, 1'b1);

        // Both request continuously.
        idle_gap(2);
        vid_req = 1'b1; vid_adr = AW'(32'h4000); vid_len = LW'(1);
        cur_req = 1'b1; cur_adr = AW'(32'h8000); cur_len = LW'(0);
        for (int k = 0; k < 6; k++) begin
            arbitrate(1'b1, 1'b1, wc);
            if (wc)
                run_burst("starve_cur", 1'b1, AW'(32'h8000), 0, 0, NO_ERR, 1'b0);
            else
                run_burst("starve_vid", 1'b0, AW'(32'h4000), 1, 0, NO_ERR, 1'b0);
        end

        // Cursor burst of three beats errors on the second beat.
        idle_gap(2);
        cur_req = 1'b1; cur_adr = AW'(32'h2000); cur_len = LW'(2);
        arbitrate(1'b0, 1'b1, wc);
        run_burst("cur_err", wc, AW'(32'h2000), 2, 0, 1, 1'b1);
        @(negedge clk);
        #1;
        chk("cur_err_no_beat3", {62'd0, wbm_cyc, cur_err}, 64'd0);

        // Asynchronous reset in the middle of a video burst.
        idle_gap(1);
        vid_req = 1'b1; vid_adr = AW'(32'h500); vid_len = LW'(7);
        for (int n = 0; n < 12 && !wbm_cyc; n++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_mid_started", {63'd0, wbm_cyc}, 64'd1);
        wbm_ack = 1'b1;
        repeat (2) @(negedge clk);
        wbm_ack = 1'b0;
        #1;
        chk("rst_mid_adr", {34'd0, wbm_adr}, {34'd0, AW'(32'h502)});
        #1;
        rst_n = 1'b0;
        wbm_ack = 1'b1;
        #1;
        chk("rst_mid_outs", {wbm_cyc, wbm_stb, vid_gnt, cur_gnt, vid_ack, wbm_adr, wbm_cti, 25'd0},
            64'd0);
        wbm_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        starve_m = 0;
        vid_adr = AW'(32'h600); vid_len = LW'(1);
        arbitrate(1'b1, 1'b0, wc);
        run_burst("after_rst", wc, AW'(32'h600), 1, 0, NO_ERR, 1'b1);

        // Single beat at the top of the address space with wait states, then a wrapping burst.
        vid_req = 1'b1; vid_adr = AW'(32'h3FFF_FFFF); vid_len = LW'(0);
        arbitrate(1'b1, 1'b0, wc);
        run_burst("single_wait", wc, AW'(32'h3FFF_FFFF), 0, 2, NO_ERR, 1'b1);
        vid_req = 1'b1; vid_len = LW'(1);
        arbitrate(1'b1, 1'b0, wc);
        run_burst("wrap", wc, AW'(32'h3FFF_FFFF), 1, 0, NO_ERR, 1'b1);

        // Randomized bursts.
        for (int k = 0; k < 24; k++) begin
            v  = 1'($urandom_range(0, 1));
            c  = v ? 1'($urandom_range(0, 1)) : 1'b1;
            rl = $urandom_range(0, 3);
            rw = $urandom_range(0, 2);
            re = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rl) : NO_ERR;
            vid_req = v; vid_adr = AW'($urandom); vid_len = LW'(rl);
            cur_req = c; cur_adr = AW'($urandom); cur_len = LW'(rl);
            arbitrate(v, c, wc);
            ra = wc ? cur_adr : vid_adr;
            run_burst("rand", wc, ra, rl, rw, re, 1'($urandom_range(0, 1)));
        end

        idle_gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_wbm_arb.md
VGA_WBM_ARB -- requirements
Module: vga_wbm_arb

Interface
REQ-001 SHALL have parameter AW, default 30, meaning word-address width (byte address bits [31:2]).
REQ-002 SHALL have parameter LW, default 4, meaning burst-length field width (length encoded as beats minus 1).
REQ-003 SHALL have parameter STARVE_LIM, default 4, meaning consecutive video grants allowed while cursor waits.
REQ-004 SHALL have port wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port arst_i  in  1  reset; asynchronous and active-low (0 = reset).
REQ-006 SHALL have ports vid_req_i  in  1, vid_adr_i  in  AW, vid_len_i  in  LW  video line-fetch request, start address, beats-1.
REQ-007 SHALL have ports vid_gnt_o  out  1, vid_ack_o  out  1, vid_err_o  out  1  video grant, per-beat data valid, error pulse.
REQ-008 SHALL have ports cur_req_i, cur_adr_i, cur_len_i, cur_gnt_o, cur_ack_o, cur_err_o  with the same widths and meanings for the cursor-buffer fetch.
REQ-009 SHALL have port dat_o  out  32  read data shared by both requesters, qualified by the requester's ack.
REQ-010 SHALL have ports wbm_cyc_o  out  1, wbm_stb_o  out  1, wbm_adr_o  out  AW, wbm_cti_o  out  3, wbm_bte_o  out  2  Wishbone B3 master controls.
REQ-011 SHALL have ports wbm_ack_i  in  1, wbm_err_i  in  1, wbm_dat_i  in  32  Wishbone slave responses.

Function
REQ-012 SHALL implement states IDLE, VID, CUR. IDLE moves to VID or CUR when a request is present. VID and CUR return to IDLE on the last ack or on err.
REQ-013 SHALL arbitrate in IDLE: video has priority, except the cursor wins when the starvation count equals STARVE_LIM.
REQ-014 SHALL, one cycle after arbitration, assert cyc/stb and the winner's gnt. It SHALL latch the winner's address and length at the arbitration edge.
REQ-015 SHALL increment wbm_adr_o by 1 on each ack; address wraps modulo 2^AW.
REQ-016 SHALL drive wbm_cti_o=3'b010 while more than one beat remains, 3'b111 on the final beat (len=0: single beat, 3'b111 from the start). wbm_bte_o is constant 2'b00.
REQ-017 SHALL pass wbm_dat_i to dat_o combinationally. The granted requester's ack equals wbm_ack_i; the other requester's ack is held at 0.
REQ-018 SHALL drop cyc, stb and gnt on the edge that samples the final ack. At least one IDLE cycle SHALL separate bursts.
REQ-019 SHALL, on wbm_err_i, end the burst at that edge and pulse the granted requester's err_o for one cycle. err SHALL take precedence if ack and err are both high.
REQ-020 SHALL ignore request deassertion mid-burst; the burst runs to completion or error.
REQ-021 SHALL count video grants issued while cur_req_i is high. The count saturates at STARVE_LIM and clears on a cursor grant or when cur_req_i is low in IDLE.
REQ-022 SHALL hold all outputs stable while ack is low (wait states, unbounded).

Reset
REQ-023 SHALL, while arst_i=0, asynchronously force state IDLE and clear the beat counter, address register and starvation count. All outputs go to 0, including mid-burst.
REQ-024 SHALL, after reset release, wait at least one cycle in IDLE before the first arbitration.

Configuration
REQ-025 SHALL honour macro VGA_ARB_STARVE_GUARD_EN. When defined: starvation logic per REQ-013/REQ-021. When undefined: the counter is removed and strict video priority applies.

Verification
REQ-026 SHALL cover: vid_req_i=1, vid_adr_i=0x100, vid_len_i=3, zero-wait acks -> four beats at adr 0x100..0x103, cti 010,010,010,111; cyc drops after the 4th ack.
REQ-027 SHALL cover: vid and cur requests in the same cycle, guard defined, STARVE_LIM=4, video re-requesting continuously -> four video bursts, then a cursor burst, then video again.
REQ-028 SHALL cover: cursor burst with len=2 and wbm_err_i on beat 2 -> cur_err_o pulses once, cyc drops the same edge, next state IDLE, no 3rd beat.
REQ-029 SHALL cover: arst_i=0 asserted mid-way through a video burst -> cyc/stb/gnt go to 0 without a clock. After release a new request restarts at the new address.
REQ-030 SHALL cover: vid_len_i=0, adr 0x3FFFFFFF, with 2 wait states -> single beat, cti 111, outputs stable during waits. The next burst at 0x3FFFFFFF with len=1 wraps to adr 0x0.
